// File: rtl/item_hit_scanner.sv
// item_hit_scanner: walks the item map's packed list one entry per cycle,
// tests the hook tip against each item's bounding box and reports the grabbed
// item.  It can also issue a one-cycle "mark moved" command to the item map.
// Optional build macro: ITEM_HIT_NEAREST_EN. When it is defined, every entry is
// scanned and the candidate whose centre is closest to the tip (Manhattan
// distance) wins. When it is not defined, the first candidate found wins.
module item_hit_scanner #(
  parameter int MAX_ITEMS = 32,
  parameter int ITEM_W    = 32,
  parameter int ITEM_H    = 32
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [MAX_ITEMS*32-1:0] item_data,
  input  logic [5:0]             quantity,
  input  logic [12:0]            hook_x,
  input  logic [11:0]            hook_y,
  input  logic                   start,
  input  logic                   grab_en,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic [5:0]             hit_index,
  output logic                   move_en,
  output logic [5:0]             move_index,
  output logic [10:0]            move_x,
  output logic [10:0]            move_y,
  output logic                   move_state,
  output logic                   visible
);

  localparam int IDX_W = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam logic [5:0]  QMAX   = 6'(MAX_ITEMS);
  localparam logic [13:0] SPAN_X = 14'(ITEM_W * 16);
  localparam logic [12:0] SPAN_Y = 13'(ITEM_H * 16);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} stateType;

  stateType stateReg, stateNext;

  logic [12:0] hookXReg;
  logic [11:0] hookYReg;
  logic [5:0]  qReg;
  logic        grabReg;
  logic [5:0]  idxReg;
  logic        hitReg;
  logic [5:0]  hitIndexReg;

  // Per-item fields unpacked from the flat bus.
  logic [12:0] itemX   [MAX_ITEMS];
  logic [11:0] itemY   [MAX_ITEMS];
  logic        itemVis [MAX_ITEMS];
  logic        itemMov [MAX_ITEMS];
  logic [MAX_ITEMS*5-1:0] unusedFields;
  logic                   unusedBits;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ITEMS; gi++) begin : g_unpack
      assign itemX[gi]   = item_data[gi*32+19 +: 13];
      assign itemY[gi]   = item_data[gi*32+7 +: 12];
      assign itemVis[gi] = item_data[gi*32+1];
      assign itemMov[gi] = item_data[gi*32];
      assign unusedFields[gi*5 +: 5] = item_data[gi*32+2 +: 5];
    end
  endgenerate

  // Bits [6:2] of each entry carry nothing this block needs.
  assign unusedBits = ^unusedFields;

  logic [5:0]  qClamped;
  logic        scanEnd;
  logic        inTable;
  logic [12:0] curX;
  logic [11:0] curY;
  logic        curVis;
  logic        curMov;
  logic        inX;
  logic        inY;
  logic        candidate;

  assign qClamped = (quantity > QMAX) ? QMAX : quantity;
  assign scanEnd  = (idxReg >= qReg);
  // The table lookup is gated so an out-of-range index is never used.
  assign inTable  = (idxReg < QMAX);
  assign curX     = inTable ? itemX[idxReg[IDX_W-1:0]]   : 13'd0;
  assign curY     = inTable ? itemY[idxReg[IDX_W-1:0]]   : 12'd0;
  assign curVis   = inTable ? itemVis[idxReg[IDX_W-1:0]] : 1'b0;
  assign curMov   = inTable ? itemMov[idxReg[IDX_W-1:0]] : 1'b0;

  // The upper bounds are widened by one bit so the box edge cannot wrap.
  assign inX = (curX <= hookXReg) &&
               ({1'b0, hookXReg} < ({1'b0, curX} + SPAN_X));
  assign inY = (curY <= hookYReg) &&
               ({1'b0, hookYReg} < ({1'b0, curY} + SPAN_Y));
  assign candidate = !scanEnd && curVis && !curMov && inX && inY;

`ifdef ITEM_HIT_NEAREST_EN
  localparam logic [13:0] HALF_X = 14'(ITEM_W * 8);
  localparam logic [12:0] HALF_Y = 13'(ITEM_H * 8);

  logic [13:0] centreX, hookX14, distX;
  logic [12:0] centreY, hookY13, distY;
  logic [14:0] dist;
  logic        bestFoundReg;
  logic [5:0]  bestIdxReg;
  logic [14:0] bestDistReg;

  // Manhattan distance from the tip to the centre of the current item.
  always_comb begin
    centreX = {1'b0, curX} + HALF_X;
    centreY = {1'b0, curY} + HALF_Y;
    hookX14 = {1'b0, hookXReg};
    hookY13 = {1'b0, hookYReg};
    distX   = (hookX14 >= centreX) ? (hookX14 - centreX) : (centreX - hookX14);
    distY   = (hookY13 >= centreY) ? (hookY13 - centreY) : (centreY - hookY13);
    dist    = {1'b0, distX} + {2'b00, distY};
  end

  // Track the best candidate; a strict compare keeps the lower index on ties.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bestFoundReg <= 1'b0;
      bestIdxReg   <= 6'd0;
      bestDistReg  <= 15'd0;
    end else if (stateReg == IDLE && start) begin
      bestFoundReg <= 1'b0;
      bestIdxReg   <= 6'd0;
      bestDistReg  <= 15'd0;
    end else if (stateReg == SCAN && candidate &&
                 (!bestFoundReg || dist < bestDistReg)) begin
      bestFoundReg <= 1'b1;
      bestIdxReg   <= idxReg;
      bestDistReg  <= dist;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  // Next-state decode and the state-derived strobes.
  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    move_en   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) stateNext = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
`ifdef ITEM_HIT_NEAREST_EN
        if (scanEnd) stateNext = REPORT;
`else
        if (scanEnd || candidate) stateNext = REPORT;
`endif
      end
      REPORT: begin
        busy      = 1'b1;
        done      = 1'b1;
        move_en   = hitReg && grabReg;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the request at start, step the index and capture the result.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hookXReg    <= 13'd0;
      hookYReg    <= 12'd0;
      qReg        <= 6'd0;
      grabReg     <= 1'b0;
      idxReg      <= 6'd0;
      hitReg      <= 1'b0;
      hitIndexReg <= 6'd0;
    end else begin
      if (stateReg == IDLE && start) begin
        hookXReg    <= hook_x;
        hookYReg    <= hook_y;
        qReg        <= qClamped;
        grabReg     <= grab_en;
        idxReg      <= 6'd0;
        hitReg      <= 1'b0;
        hitIndexReg <= 6'd0;
      end else if (stateReg == SCAN) begin
        if (!scanEnd) idxReg <= idxReg + 6'd1;
`ifdef ITEM_HIT_NEAREST_EN
        if (scanEnd) begin
          hitReg      <= bestFoundReg;
          hitIndexReg <= bestIdxReg;
        end
`else
        if (candidate) begin
          hitReg      <= 1'b1;
          hitIndexReg <= idxReg;
        end
`endif
      end
    end
  end

  assign hit        = hitReg;
  assign hit_index  = hitIndexReg;
  assign move_index = hitIndexReg;
  assign move_x     = 11'd0;
  assign move_y     = 11'd0;
  assign move_state = 1'b1;
  assign visible    = 1'b1;

endmodule
